// File: rtl/mean_calculator.sv
// mean_calculator: per-axis mean of COUNT signed samples using two parallel restoring dividers.
// Define MEAN_CALCULATOR_ROUND_EN for round-to-nearest (ties away from zero) instead of truncation.
module mean_calculator #(
    parameter int WIDTH = 20,
    parameter int COUNT = 150,
    localparam int CNT_WIDTH = $clog2(COUNT + 1),
    localparam int ACC_WIDTH = WIDTH + CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_in_x,
    input  logic [WIDTH-1:0] i_in_y,
    input  logic             i_in_valid,
    output logic [WIDTH-1:0] o_mean_x,
    output logic [WIDTH-1:0] o_mean_y,
    output logic             o_busy,
    output logic             o_ready
);
    localparam int IT_WIDTH = $clog2(ACC_WIDTH + 1);
    localparam logic [CNT_WIDTH:0] DIVISOR = (CNT_WIDTH + 1)'(COUNT);
`ifdef MEAN_CALCULATOR_ROUND_EN
    localparam logic [ACC_WIDTH-1:0] BIAS = ACC_WIDTH'(COUNT / 2);
`else
    localparam logic [ACC_WIDTH-1:0] BIAS = '0;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [ACC_WIDTH-1:0] r_acc_x, r_acc_y, r_quo_x, r_quo_y;
    logic [CNT_WIDTH-1:0] r_cnt, r_rem_x, r_rem_y;
    logic [IT_WIDTH-1:0]  r_it;
    logic                 r_neg_x, r_neg_y;

    logic [ACC_WIDTH-1:0] w_sum_x, w_sum_y, w_mag_x, w_mag_y, w_quo_x, w_quo_y;
    logic [CNT_WIDTH:0]   w_sh_x, w_sh_y;
    logic [CNT_WIDTH-1:0] w_rem_x, w_rem_y;
    logic [WIDTH-1:0]     w_res_x, w_res_y;
    logic                 w_ge_x, w_ge_y, w_last, w_div_last;

    assign w_sum_x = r_acc_x + {{CNT_WIDTH{i_in_x[WIDTH-1]}}, i_in_x};
    assign w_sum_y = r_acc_y + {{CNT_WIDTH{i_in_y[WIDTH-1]}}, i_in_y};
    // Divider is loaded from the sum that includes the final sample, so DIVIDE starts on the next edge.
    assign w_mag_x = (w_sum_x[ACC_WIDTH-1] ? -w_sum_x : w_sum_x) + BIAS;
    assign w_mag_y = (w_sum_y[ACC_WIDTH-1] ? -w_sum_y : w_sum_y) + BIAS;

    assign w_sh_x  = {r_rem_x, r_quo_x[ACC_WIDTH-1]};
    assign w_sh_y  = {r_rem_y, r_quo_y[ACC_WIDTH-1]};
    assign w_ge_x  = w_sh_x >= DIVISOR;
    assign w_ge_y  = w_sh_y >= DIVISOR;
    assign w_rem_x = CNT_WIDTH'(w_ge_x ? w_sh_x - DIVISOR : w_sh_x);
    assign w_rem_y = CNT_WIDTH'(w_ge_y ? w_sh_y - DIVISOR : w_sh_y);
    assign w_quo_x = {r_quo_x[ACC_WIDTH-2:0], w_ge_x};
    assign w_quo_y = {r_quo_y[ACC_WIDTH-2:0], w_ge_y};
    assign w_res_x = WIDTH'(r_neg_x ? -w_quo_x : w_quo_x);
    assign w_res_y = WIDTH'(r_neg_y ? -w_quo_y : w_quo_y);

    assign w_last     = r_cnt == CNT_WIDTH'(COUNT - 1);
    assign w_div_last = r_it == IT_WIDTH'(ACC_WIDTH - 1);
    assign o_busy     = (r_state == ACCUM) || (r_state == DIVIDE);
    assign o_ready    = r_state == DONE;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = i_start ? ACCUM : IDLE;
            ACCUM:   w_state_nxt = (i_in_valid && w_last) ? DIVIDE : ACCUM;
            DIVIDE:  w_state_nxt = w_div_last ? DONE : DIVIDE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_x  <= '0;
            r_acc_y  <= '0;
            r_cnt    <= '0;
            r_quo_x  <= '0;
            r_quo_y  <= '0;
            r_rem_x  <= '0;
            r_rem_y  <= '0;
            r_neg_x  <= 1'b0;
            r_neg_y  <= 1'b0;
            r_it     <= '0;
            o_mean_x <= '0;
            o_mean_y <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                        r_cnt   <= '0;
                    end
                end
                ACCUM: begin
                    if (i_in_valid) begin
                        r_acc_x <= w_sum_x;
                        r_acc_y <= w_sum_y;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_quo_x <= w_mag_x;
                            r_quo_y <= w_mag_y;
                            r_rem_x <= '0;
                            r_rem_y <= '0;
                            r_neg_x <= w_sum_x[ACC_WIDTH-1];
                            r_neg_y <= w_sum_y[ACC_WIDTH-1];
                            r_it    <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    r_quo_x <= w_quo_x;
                    r_quo_y <= w_quo_y;
                    r_rem_x <= w_rem_x;
                    r_rem_y <= w_rem_y;
                    r_it    <= r_it + 1'b1;
                    if (w_div_last) begin
                        o_mean_x <= w_res_x;
                        o_mean_y <= w_res_y;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mean_calculator.sv
// tb_mean_calculator: scoreboard bench for mean_calculator (COUNT=150 instance plus a COUNT=4 rounding instance).
module tb_mean_calculator;
    localparam int W    = 20;
    localparam int N    = 150;
    localparam int ACC  = W + $clog2(N + 1);
    localparam int N4   = 4;
    localparam int ACC4 = W + $clog2(N4 + 1);
    localparam logic [W-1:0] JUNK = 20'h5A5A5;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, in_valid = 1'b0;
    logic [W-1:0] in_x = '0, in_y = '0;
    logic [W-1:0] mean_x, mean_y;
    logic busy, ready;
    logic s4_start = 1'b0, s4_valid = 1'b0;
    logic [W-1:0] s4_x = '0, s4_y = '0;
    logic [W-1:0] m4_x, m4_y;
    logic busy4, ready4;

    exp_t q[$];
    exp_t q4[$];
    int cyc = 0, n_checks = 0, n_errors = 0, rdy_cnt = 0, t_start = 0;
    logic [W-1:0] xs[N];
    logic [W-1:0] ys[N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mean_calculator #(.WIDTH(W), .COUNT(N)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_in_x(in_x), .i_in_y(in_y),
        .i_in_valid(in_valid), .o_mean_x(mean_x), .o_mean_y(mean_y),
        .o_busy(busy), .o_ready(ready)
    );

    mean_calculator #(.WIDTH(W), .COUNT(N4)) u_dut4 (
        .clk(clk), .rst(rst), .i_start(s4_start), .i_in_x(s4_x), .i_in_y(s4_y),
        .i_in_valid(s4_valid), .o_mean_x(m4_x), .o_mean_y(m4_y),
        .o_busy(busy4), .o_ready(ready4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input longint s, input int n);
        longint m;
        m = (s < 0) ? -s : s;
`ifdef MEAN_CALCULATOR_ROUND_EN
        m = m + n / 2;
`endif
        m = m / n;
        return W'((s < 0) ? -m : m);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready) begin
            rdy_cnt++;
            check("busy_with_ready", 32'(busy), 0);
            if (q.size() == 0) check("unexpected_ready", 32'(q.size()), 1);
            else begin
                e = q.pop_front();
                check("mean_x", 32'(mean_x), 32'(e.x));
                check("mean_y", 32'(mean_y), 32'(e.y));
                check("ready_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ready4) begin
            if (q4.size() == 0) check("unexpected_ready4", 32'(q4.size()), 1);
            else begin
                e = q4.pop_front();
                check("round_mean_x", 32'(m4_x), 32'(e.x));
                check("round_mean_y", 32'(m4_y), 32'(e.y));
                check("round_ready_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic v, input logic st);
        in_x = x;
        in_y = y;
        in_valid = v;
        start = st;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 1);
    endtask

    task automatic start_run(input bit from_done);
        if (from_done) begin
            wait_ready();
            send(JUNK, JUNK, 1'b1, 1'b1);
            check("start_in_done_ignored", 32'(busy), 0);
        end
        send(JUNK, JUNK, 1'b1, 1'b1);
        t_start = cyc;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic fill(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 0; i < N; i++) begin
            xs[i] = x;
            ys[i] = y;
        end
    endtask

    task automatic run(input bit gaps, input bit poke, input bit from_done);
        longint sx = 0, sy = 0;
        for (int i = 0; i < N; i++) begin
            sx += longint'($signed(xs[i]));
            sy += longint'($signed(ys[i]));
        end
        start_run(from_done);
        q.push_back('{model(sx, N), model(sy, N), t_start + (gaps ? 2 * N : N) + ACC});
        for (int i = 0; i < N; i++) begin
            if (gaps) send(JUNK, JUNK, 1'b0, 1'b0);
            send(xs[i], ys[i], 1'b1, poke && i == 10);
        end
        repeat (4) send(JUNK, JUNK, 1'b1, poke);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_mean_x", 32'(mean_x), 0);
        check("rst_mean_y", 32'(mean_y), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(ready), 0);
        rst = 1'b0;
        send(JUNK, JUNK, 1'b1, 1'b0);
        check("idle_ignores_valid", 32'(busy), 0);

        fill(20'h00400, 20'hFFC00);
        run(1'b0, 1'b0, 1'b0);
        run(1'b1, 1'b0, 1'b1);
        run(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
        end
        run(1'b0, 1'b0, 1'b1);
        fill(20'h7FFFF, 20'h80000);
        run(1'b0, 1'b0, 1'b1);

        wait_ready();
        repeat (2) send(JUNK, JUNK, 1'b1, 1'b0);
        start_run(1'b0);
        for (int i = 0; i < 59; i++) send(20'h00800, 20'h00800, 1'b1, 1'b0);
        in_x = 20'h00800;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_mean_x", 32'(mean_x), 0);
        check("abort_mean_y", 32'(mean_y), 0);
        check("abort_busy", 32'(busy), 0);
        rst = 1'b0;
        send(JUNK, JUNK, 1'b1, 1'b0);
        fill(20'h00800, 20'hFF800);
        run(1'b0, 1'b0, 1'b0);

        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        q4.push_back('{model(3, N4), model(-3, N4), cyc + N4 + ACC4});
        for (int i = 0; i < N4; i++) begin
            s4_x = (i < 3) ? 20'h00001 : 20'h00000;
            s4_y = (i < 3) ? 20'hFFFFF : 20'h00000;
            s4_valid = 1'b1;
            @(negedge clk);
        end
        s4_valid = 1'b0;

        k = 0;
        while ((q.size() + q4.size()) != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("scoreboard_drained", 32'(q.size() + q4.size()), 0);
        check("ready_count", rdy_cnt, 6);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mean_calculator.md
# mean_calculator

Computes the arithmetic means of the X and Y sample sets for the linear-regression pipeline. It sits directly downstream of the data loader. The loader pulses `start` and streams its stored samples. This block accumulates `COUNT` signed samples per axis, divides each sum by `COUNT` with a sequential divider, and returns the means with a one-cycle `ready` pulse. The loader's `meanReady` input is driven by that pulse, and the means then feed the coefficient calculator.

## Interface
- `WIDTH`, 20: sample and mean width; signed two's complement, 10.10 fixed point.
- `COUNT`, 150: samples per run; must be at least 1.
- `CNT_WIDTH`, `$clog2(COUNT+1)`: width of the sample counter; derived, not overridden.
- `ACC_WIDTH`, `WIDTH+CNT_WIDTH`: width of the accumulators and the divider; derived.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset; synchronous and active-high.
- `start`, input, 1: begin a run; sampled only in IDLE.
- `inX`, input, WIDTH: X sample.
- `inY`, input, WIDTH: Y sample.
- `inValid`, input, 1: `inX`/`inY` hold a valid sample this cycle.
- `meanX`, output, WIDTH: mean of X; held until the next DONE.
- `meanY`, output, WIDTH: mean of Y; held until the next DONE.
- `busy`, output, 1: high in ACCUM and DIVIDE.
- `ready`, output, 1: one-cycle pulse in DONE.

## Operation
- The FSM has four states: IDLE, ACCUM, DIVIDE and DONE.
- **IDLE**
  - `start`=1 clears `accX`, `accY` and `cnt`, then moves to ACCUM.
  - `inValid` is ignored in IDLE.
- **ACCUM**
  - On each cycle with `inValid`=1, `accX += sext(inX)`, `accY += sext(inY)` and `cnt++`.
  - Accumulation is signed; the ACC_WIDTH width cannot overflow for COUNT samples.
  - Cycles with `inValid`=0 leave all state unchanged.
  - The edge that accepts sample number COUNT (`cnt`==COUNT-1 with `inValid`=1) moves to DIVIDE.
- **DIVIDE**
  - Each axis divides its magnitude by COUNT in its own restoring divider. The two dividers run in parallel, one quotient bit per cycle, for ACC_WIDTH cycles.
  - When the iteration count reaches ACC_WIDTH, the FSM moves to DONE.
- **DONE**
  - Result per axis = sign(acc) × quotient, truncated to WIDTH bits. The mean of WIDTH-bit values always fits in WIDTH bits.
  - `meanX` and `meanY` are registered on entry to DONE.
  - `ready`=1 for exactly this cycle, then the FSM returns to IDLE.
- `start` is ignored outside IDLE; a run is never restarted or queued.
- A `start` that arrives in the DONE cycle is ignored. `start` asserted in the IDLE cycle immediately after DONE is honoured.
- `inValid` in DIVIDE or DONE is ignored and the sample is dropped.

## Timing
- Reset values: state = IDLE; `accX`, `accY`, `cnt` and the divider registers = 0; `meanX`=0, `meanY`=0, `busy`=0, `ready`=0.
- Reset mid-run aborts the run. No `ready` is produced and the previous means are lost (they return to 0).
- `start` sampled at edge t: ACCUM is entered at t and `busy`=1 from cycle t+1.
- With COUNT back-to-back valid samples, the last sample is accepted at edge t+COUNT.
- DIVIDE occupies cycles t+COUNT+1 through t+COUNT+ACC_WIDTH.
- `ready` is high in cycle t+COUNT+ACC_WIDTH+1. For the defaults that is t+179.
- `meanX`/`meanY` become valid in the same cycle as `ready` and stay stable until the next DONE or `rst`.
- `busy` and `ready` are never high in the same cycle.
- Gaps in `inValid` lengthen ACCUM one cycle per gap cycle; DIVIDE length is fixed.

## Configuration
- Macro: `MEAN_CALCULATOR_ROUND_EN`.
- Defined: before division, add `floor(COUNT/2)` to the magnitude. The result is round-to-nearest, with ties rounded away from zero.
- Undefined: no bias is added; the quotient truncates toward zero.
- Latency is identical in both builds.

## Test plan
- **Constant input:** COUNT=150, all samples `inX`=0x00400 (1.0), `inY`=0xFFC00 (−1.0), back-to-back -> `meanX`=0x00400, `meanY`=0xFFC00, `ready` exactly at t+179.
- **Gaps:** same data with `inValid` low every other cycle -> same means, `ready` at t+329.
- **Start while busy:** `start` re-pulsed during ACCUM and DIVIDE -> no restart, one `ready`, correct means.
- **Reset mid-run:** `rst` asserted during sample 60, then a clean run of COUNT=150 samples with `inX`=0x00800 (2.0) -> `meanX`=0x00800 and only one `ready` pulse, for the clean run.
- **Rounding:** COUNT=4, `inX` raw samples 1,1,1,0 and `inY` raw samples −1,−1,−1,0:
  - Without `MEAN_CALCULATOR_ROUND_EN`: `meanX`=0, `meanY`=0.
  - With it: `meanX`=1, `meanY`=0xFFFFF.
- **Extremes:** COUNT=150, all `inX`=0x7FFFF and all `inY`=0x80000 -> `meanX`=0x7FFFF, `meanY`=0x80000, with no overflow.
